// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, grant/return and RAM-side signals of the
// shared data-memory port. The arbiter takes the slave view. Requesters and
// the RAM take the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          x_req;
    logic          x_we;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_wdata;

    logic          f_gnt;
    logic          d_gnt;
    logic          x_gnt;
    logic          f_rvalid;
    logic          d_rvalid;
    logic          x_rvalid;
    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [15:0]   conflict_cnt;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
               x_req, x_we, x_addr, x_wdata, mem_rdata,
        input  f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
               x_req, x_we, x_addr, x_wdata, mem_rdata,
        output f_gnt, d_gnt, x_gnt, f_rvalid, d_rvalid, x_rvalid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block-RAM port between instruction fetch (F),
// data access (D) and an external loader (X). D has priority. F and X
// alternate round-robin. X is forced ahead of D after MAX_WAIT lost cycles.
// Read data is steered back to its owner through a tag pipeline that is
// RD_LAT deep.
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D, OWN_X} owner_e;
    typedef enum logic {RR_F, RR_X} rr_e;

    rr_e           rr_ptr;
    logic [SW-1:0] starve_cnt;
    owner_e        tag_q [RD_LAT];
    logic [15:0]   conflict_q;

    logic          f_win;
    logic          d_win;
    logic          x_win;
    logic          x_starved;
    logic          multi_req;
    owner_e        rd_owner;
    owner_e        tag_out;
    logic          we_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    assign x_starved = bus.x_req && (starve_cnt == SW'(MAX_WAIT));
    assign multi_req = (bus.f_req && bus.d_req) || (bus.f_req && bus.x_req) ||
                       (bus.d_req && bus.x_req);
    assign tag_out   = tag_q[RD_LAT-1];

    // Pick this cycle's single winner. Nothing is granted while reset is held.
    always_comb begin
        f_win = 1'b0;
        d_win = 1'b0;
        x_win = 1'b0;
        if (rst_n) begin
            if (x_starved) begin
                x_win = 1'b1;
            end else if (bus.d_req) begin
                d_win = 1'b1;
            end else if (rr_ptr == RR_F) begin
                if (bus.f_req)      f_win = 1'b1;
                else if (bus.x_req) x_win = 1'b1;
            end else begin
                if (bus.x_req)      x_win = 1'b1;
                else if (bus.f_req) f_win = 1'b1;
            end
        end
    end

    // Steer the winner's access onto the RAM port and tag reads with their owner.
    always_comb begin
        we_mux    = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        rd_owner  = OWN_NONE;
        if (d_win) begin
            we_mux    = bus.d_we;
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
            if (!bus.d_we) rd_owner = OWN_D;
        end else if (x_win) begin
            we_mux    = bus.x_we;
            addr_mux  = bus.x_addr;
            wdata_mux = bus.x_wdata;
            if (!bus.x_we) rd_owner = OWN_X;
        end else if (f_win) begin
            addr_mux  = bus.f_addr;
            rd_owner  = OWN_F;
        end
    end

    assign bus.f_gnt     = f_win;
    assign bus.d_gnt     = d_win;
    assign bus.x_gnt     = x_win;
    assign bus.mem_en    = f_win || d_win || x_win;
    assign bus.mem_we    = we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    assign bus.f_rvalid     = rst_n && (tag_out == OWN_F);
    assign bus.d_rvalid     = rst_n && (tag_out == OWN_D);
    assign bus.x_rvalid     = rst_n && (tag_out == OWN_X);
    assign bus.rdata        = bus.mem_rdata;
    assign bus.conflict_cnt = conflict_q;

    // Advance the round-robin pointer, starvation counter, read-owner pipeline and conflict count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= RR_F;
            starve_cnt <= '0;
            conflict_q <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= OWN_NONE;
        end else begin
            if (f_win)      rr_ptr <= RR_X;
            else if (x_win) rr_ptr <= RR_F;

            if (!bus.x_req || x_win)
                starve_cnt <= '0;
            else if (starve_cnt != SW'(MAX_WAIT))
                starve_cnt <= starve_cnt + SW'(1);

            tag_q[0] <= rd_owner;
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];

            if (multi_req && (conflict_q != 16'hFFFF))
                conflict_q <= conflict_q + 16'd1;
        end
    end
endmodule
